// File: rtl/sme_job_scheduler_if.sv
// Client-side bus of the string-match job scheduler: request/grant, shared char bus, tagged result.
// master = requester side, slave = scheduler side.
interface sme_job_scheduler_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [7:0]      s_data;
  logic            s_isstring;
  logic            s_ispattern;
  logic            s_last;
  logic            rsp_valid;
  logic [2:0]      rsp_id;
  logic            rsp_match;
  logic [4:0]      rsp_index;
  logic            rsp_err;

  modport master (
    output req, s_data, s_isstring, s_ispattern, s_last,
    input  gnt, rsp_valid, rsp_id, rsp_match, rsp_index, rsp_err
  );

  modport slave (
    input  req, s_data, s_isstring, s_ispattern, s_last,
    output gnt, rsp_valid, rsp_id, rsp_match, rsp_index, rsp_err
  );
endinterface

// File: rtl/sme_job_scheduler.sv
// Round-robin scheduler sharing one char-serial string-match engine among NREQ requesters.
// Optional statistics counters are enabled by defining SME_SCHED_STATS_EN.
module sme_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 96
) (
  input  logic        clk,
  input  logic        reset,
  sme_job_scheduler_if.slave bus,
  output logic [7:0]  eng_chardata,
  output logic        eng_isstring,
  output logic        eng_ispattern,
  input  logic        eng_match,
  input  logic [4:0]  eng_index,
  input  logic        eng_valid
`ifdef SME_SCHED_STATS_EN
  ,
  output logic [15:0] stat_jobs,
  output logic [15:0] stat_match,
  output logic [15:0] stat_err
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRANT  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam int IDW = 3;
  localparam int SCW = $clog2(STR_MAX + 1);
  localparam int PCW = $clog2(PAT_MAX + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  genvar gi;

  logic [2:0]      state_reg;
  logic [IDW-1:0]  rr_reg;
  logic [IDW-1:0]  winner_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [SCW-1:0]  str_cnt_reg;
  logic [PCW-1:0]  pat_cnt_reg;
  logic [TCW-1:0]  timer_reg;
  logic            pat_seen_reg;
  logic            err_reg;

  logic [7:0]      eng_chardata_reg;
  logic            eng_isstring_reg;
  logic            eng_ispattern_reg;

  logic            rsp_valid_reg;
  logic [2:0]      rsp_id_reg;
  logic            rsp_match_reg;
  logic [4:0]      rsp_index_reg;
  logic            rsp_err_reg;

  // Arbitration: rotate requests so bit 0 is the rr pointer, take the lowest set bit.
  logic [NREQ-1:0] req_rot;
  logic [IDW-1:0]  pick_off;
  logic            pick_found;
  logic [IDW:0]    pick_sum;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  rr_next;
  logic [NREQ-1:0] gnt_onehot;

  assign req_rot = NREQ'({bus.req, bus.req} >> rr_reg);

  always_comb begin
    pick_off   = '0;
    pick_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_off   = IDW'(i);
        pick_found = 1'b1;
      end
    end
  end

  assign pick_sum = {1'b0, rr_reg} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= (IDW+1)'(NREQ)) ? IDW'(pick_sum - (IDW+1)'(NREQ))
                                                  : IDW'(pick_sum);
  assign rr_next  = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign gnt_onehot[gi] = (winner_reg == IDW'(gi));
    end
  endgenerate

  // Stream-phase char classification.
  logic in_stream;
  logic str_full;
  logic pat_full;
  logic str_char;
  logic pat_char;
  logic fwd_str;
  logic fwd_pat;
  logic bad_now;
  logic err_now;
  logic job_end;

  assign in_stream = (state_reg == S_STREAM);
  assign str_full  = (str_cnt_reg == SCW'(STR_MAX));
  assign pat_full  = (pat_cnt_reg == PCW'(PAT_MAX));
  assign str_char  = bus.s_isstring & ~bus.s_ispattern;
  assign pat_char  = bus.s_ispattern & ~bus.s_isstring;

  // Once a job is flagged bad nothing more reaches the engine; it is never waited on.
  assign fwd_str = in_stream & ~err_reg & str_char & ~pat_seen_reg & ~str_full;
  assign fwd_pat = in_stream & ~err_reg & pat_char & ~pat_full;
  assign bad_now = in_stream & ((bus.s_isstring & bus.s_ispattern)
                              | (bus.s_isstring & pat_seen_reg)
                              | (str_char & str_full)
                              | (pat_char & pat_full));
  assign err_now = err_reg | bad_now;
  assign job_end = in_stream & bus.s_ispattern & bus.s_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      rr_reg            <= '0;
      winner_reg        <= '0;
      gnt_reg           <= '0;
      str_cnt_reg       <= '0;
      pat_cnt_reg       <= '0;
      timer_reg         <= '0;
      pat_seen_reg      <= 1'b0;
      err_reg           <= 1'b0;
      eng_chardata_reg  <= '0;
      eng_isstring_reg  <= 1'b0;
      eng_ispattern_reg <= 1'b0;
      rsp_valid_reg     <= 1'b0;
      rsp_id_reg        <= '0;
      rsp_match_reg     <= 1'b0;
      rsp_index_reg     <= '0;
      rsp_err_reg       <= 1'b0;
    end else begin
      eng_isstring_reg  <= fwd_str;
      eng_ispattern_reg <= fwd_pat;
      eng_chardata_reg  <= (fwd_str | fwd_pat) ? bus.s_data : 8'd0;

      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_match_reg <= 1'b0;
      rsp_index_reg <= '0;
      rsp_err_reg   <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (pick_found) begin
            winner_reg <= pick_idx;
            rr_reg     <= rr_next;
            state_reg  <= S_GRANT;
          end
        end

        S_GRANT: begin
          gnt_reg      <= gnt_onehot;
          str_cnt_reg  <= '0;
          pat_cnt_reg  <= '0;
          pat_seen_reg <= 1'b0;
          err_reg      <= 1'b0;
          state_reg    <= S_STREAM;
        end

        S_STREAM: begin
          if (fwd_str) str_cnt_reg <= str_cnt_reg + 1'b1;
          if (fwd_pat) pat_cnt_reg <= pat_cnt_reg + 1'b1;
          if (pat_char) pat_seen_reg <= 1'b1;
          err_reg <= err_now;
          if (job_end) begin
            gnt_reg <= '0;
            if (err_now) begin
              rsp_valid_reg <= 1'b1;
              rsp_id_reg    <= winner_reg;
              rsp_err_reg   <= 1'b1;
              state_reg     <= S_RESP;
            end else begin
              state_reg <= S_GAP;
            end
          end
        end

        S_GAP: begin
          timer_reg <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (eng_valid) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= winner_reg;
            rsp_match_reg <= eng_match;
            rsp_index_reg <= eng_match ? eng_index : 5'd0;
            state_reg     <= S_RESP;
          end else if (timer_reg == TCW'(TIMEOUT - 1)) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= winner_reg;
            rsp_err_reg   <= 1'b1;
            state_reg     <= S_RESP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        S_RESP: state_reg <= S_IDLE;

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_match = rsp_match_reg;
  assign bus.rsp_index = rsp_index_reg;
  assign bus.rsp_err   = rsp_err_reg;

  assign eng_chardata  = eng_chardata_reg;
  assign eng_isstring  = eng_isstring_reg;
  assign eng_ispattern = eng_ispattern_reg;

`ifdef SME_SCHED_STATS_EN
  logic [2:0] stat_inc;
  assign stat_inc = {rsp_valid_reg & rsp_err_reg, rsp_valid_reg & rsp_match_reg, rsp_valid_reg};

  // Saturating counters: index 0 all jobs, 1 matches, 2 errors.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (stat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign stat_jobs  = g_stat[0].cnt_reg;
  assign stat_match = g_stat[1].cnt_reg;
  assign stat_err   = g_stat[2].cnt_reg;
`endif

endmodule
